// File: rtl/kcpsm3_alu_responder.sv
// KCPSM3-style ALU responder: two-stage valid/ready pipeline.
// Stage 1 captures the operation fields. Stage 2 holds the computed result,
// the flags and the tag, and drives the output ports.
module kcpsm3_alu_responder #(
  parameter int OPERAND_WIDTH = 8,
  parameter int TAG_WIDTH     = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [3:0]               opcode,
  input  logic [1:0]               shift_op,
  input  logic                     shift_dir,
  input  logic                     shift_constant,
  input  logic                     carry_in,
  input  logic [OPERAND_WIDTH-1:0] operand_a,
  input  logic [OPERAND_WIDTH-1:0] operand_b,
  input  logic [TAG_WIDTH-1:0]     op_tag,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [OPERAND_WIDTH-1:0] result,
  output logic                     carry_out,
  output logic                     zero_out,
  output logic                     flags_we,
  output logic                     reg_we,
  output logic                     illegal,
  output logic [TAG_WIDTH-1:0]     res_tag,
  output logic [CNT_WIDTH-1:0]     retired_cnt,
  output logic [CNT_WIDTH-1:0]     illegal_cnt
);
  localparam int W = OPERAND_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Stage 1 registers
  logic                 v1_q, v1_d;
  logic [3:0]           opc_q, opc_d;
  logic [1:0]           sop_q, sop_d;
  logic                 sdir_q, sdir_d;
  logic                 sconst_q, sconst_d;
  logic                 cin_q, cin_d;
  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic [TAG_WIDTH-1:0] tag1_q, tag1_d;

  // Stage 2 registers
  logic                 v2_q, v2_d;
  logic [W-1:0]         res_q, res_d;
  logic                 c_q, c_d, z_q, z_d, fwe_q, fwe_d, rwe_q, rwe_d, ill_q, ill_d;
  logic [TAG_WIDTH-1:0] tag2_q, tag2_d;
  logic [CNT_WIDTH-1:0] ret_q, ret_d, icnt_q, icnt_d;

  // Combinational ALU outputs computed from stage 1
  logic [W-1:0] alu_res;
  logic         alu_c, alu_z, alu_fwe, alu_rwe, alu_ill;
  logic [W:0]   sum_ext, diff_ext;
  logic [W-1:0] test_and;
  logic         shift_fill, shift_out;

  logic s2_load, out_xfer, in_xfer;

  assign s2_load  = !v2_q || res_ready;
  assign op_ready = !v1_q || s2_load;
  assign in_xfer  = op_valid && op_ready;
  assign out_xfer = v2_q && res_ready;

  // ALU: result and flags of the operation held in stage 1
  always_comb begin
    sum_ext    = {1'b0, a_q} + {1'b0, b_q} +
                 {{W{1'b0}}, (opc_q == 4'd5) ? cin_q : 1'b0};
    diff_ext   = {1'b0, a_q} - {1'b0, b_q} -
                 {{W{1'b0}}, (opc_q == 4'd7) ? cin_q : 1'b0};
    test_and   = a_q & b_q;
    shift_out  = sdir_q ? a_q[0] : a_q[W-1];
    case (sop_q)
      2'd0:    shift_fill = sconst_q;
      2'd1:    shift_fill = sdir_q ? a_q[W-1] : a_q[0];
      2'd2:    shift_fill = cin_q;
      default: shift_fill = shift_out;
    endcase
    alu_res = '0;
    alu_c   = 1'b0;
    alu_z   = 1'b0;
    alu_fwe = 1'b1;
    alu_rwe = 1'b1;
    alu_ill = 1'b0;
    case (opc_q)
      4'd0: begin
        alu_res = b_q;
        alu_c   = cin_q;
        alu_fwe = 1'b0;
      end
      4'd1: alu_res = a_q & b_q;
      4'd2: alu_res = a_q | b_q;
      4'd3: alu_res = a_q ^ b_q;
      4'd4, 4'd5: begin
        alu_res = sum_ext[W-1:0];
        alu_c   = sum_ext[W];
      end
      4'd6, 4'd7: begin
        alu_res = diff_ext[W-1:0];
        alu_c   = diff_ext[W];
      end
      4'd8: begin
        alu_res = a_q;
        alu_c   = diff_ext[W];
        alu_rwe = 1'b0;
      end
      4'd9: begin
        alu_res = a_q;
        alu_c   = ^test_and;
        alu_rwe = 1'b0;
      end
      4'd10: begin
        alu_res = sdir_q ? {shift_fill, a_q[W-1:1]} : {a_q[W-2:0], shift_fill};
        alu_c   = shift_out;
      end
      default: begin
        alu_fwe = 1'b0;
        alu_rwe = 1'b0;
        alu_ill = 1'b1;
      end
    endcase
    // Zero flag: LOAD never sets it, COMPARE uses the difference, TEST uses a&b
    case (opc_q)
      4'd0:    alu_z = 1'b0;
      4'd8:    alu_z = (diff_ext[W-1:0] == '0);
      4'd9:    alu_z = (test_and == '0);
      4'd11, 4'd12, 4'd13, 4'd14, 4'd15: alu_z = 1'b0;
      default: alu_z = (alu_res == '0);
    endcase
  end

  // Next-state for both stages and the retire counters
  always_comb begin
    v1_d = v1_q; opc_d = opc_q; sop_d = sop_q; sdir_d = sdir_q; sconst_d = sconst_q;
    cin_d = cin_q; a_d = a_q; b_d = b_q; tag1_d = tag1_q;
    v2_d = v2_q; res_d = res_q; c_d = c_q; z_d = z_q; fwe_d = fwe_q; rwe_d = rwe_q;
    ill_d = ill_q; tag2_d = tag2_q; ret_d = ret_q; icnt_d = icnt_q;
    // Stage 1 empties whenever it can hand off and nothing new arrives
    if (op_ready) v1_d = op_valid;
    if (in_xfer) begin
      opc_d = opcode; sop_d = shift_op; sdir_d = shift_dir; sconst_d = shift_constant;
      cin_d = carry_in; a_d = operand_a; b_d = operand_b; tag1_d = op_tag;
    end
    if (s2_load) begin
      v2_d = v1_q;
      if (v1_q) begin
        res_d = alu_res; c_d = alu_c; z_d = alu_z; fwe_d = alu_fwe;
        rwe_d = alu_rwe; ill_d = alu_ill; tag2_d = tag1_q;
      end
    end
    if (out_xfer) begin
      ret_d = ret_q + CNT_ONE;
      if (ill_q) icnt_d = icnt_q + CNT_ONE;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q <= 1'b0; opc_q <= '0; sop_q <= '0; sdir_q <= 1'b0; sconst_q <= 1'b0;
      cin_q <= 1'b0; a_q <= '0; b_q <= '0; tag1_q <= '0;
      v2_q <= 1'b0; res_q <= '0; c_q <= 1'b0; z_q <= 1'b0; fwe_q <= 1'b0;
      rwe_q <= 1'b0; ill_q <= 1'b0; tag2_q <= '0; ret_q <= '0; icnt_q <= '0;
    end else begin
      v1_q <= v1_d; opc_q <= opc_d; sop_q <= sop_d; sdir_q <= sdir_d; sconst_q <= sconst_d;
      cin_q <= cin_d; a_q <= a_d; b_q <= b_d; tag1_q <= tag1_d;
      v2_q <= v2_d; res_q <= res_d; c_q <= c_d; z_q <= z_d; fwe_q <= fwe_d;
      rwe_q <= rwe_d; ill_q <= ill_d; tag2_q <= tag2_d; ret_q <= ret_d; icnt_q <= icnt_d;
    end
  end

  assign res_valid   = v2_q;
  assign result      = res_q;
  assign carry_out   = c_q;
  assign zero_out    = z_q;
  assign flags_we    = fwe_q;
  assign reg_we      = rwe_q;
  assign illegal     = ill_q;
  assign res_tag     = tag2_q;
  assign retired_cnt = ret_q;
  assign illegal_cnt = icnt_q;
endmodule

// File: tb/tb_kcpsm3_alu_responder.sv
// Scoreboard bench for kcpsm3_alu_responder: expected responses are queued at
// input transfers and popped by an independent monitor at output transfers.
module tb_kcpsm3_alu_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_ready;
  logic [3:0]  opcode;
  logic [1:0]  shift_op;
  logic        shift_dir, shift_constant, carry_in;
  logic [7:0]  operand_a, operand_b;
  logic [3:0]  op_tag;
  logic        res_valid, res_ready;
  logic [7:0]  result;
  logic        carry_out, zero_out, flags_we, reg_we, illegal;
  logic [3:0]  res_tag;
  logic [15:0] retired_cnt, illegal_cnt;

  kcpsm3_alu_responder #(.OPERAND_WIDTH(8), .TAG_WIDTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .shift_op(shift_op), .shift_dir(shift_dir),
    .shift_constant(shift_constant), .carry_in(carry_in),
    .operand_a(operand_a), .operand_b(operand_b), .op_tag(op_tag),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .carry_out(carry_out), .zero_out(zero_out), .flags_we(flags_we),
    .reg_we(reg_we), .illegal(illegal), .res_tag(res_tag),
    .retired_cnt(retired_cnt), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] tag;
    logic [7:0] res;
    logic       c, z, fw, rw, ill;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   rr_mode = 0;     // 0 always ready, 1 toggle, 2 random, 3 stalled
  int   tag_seq = 0;
  int   sent_total = 0;
  int   sent_illegal = 0;
  int   mon_ret = 0;
  int   mon_ill = 0;
  logic held_v = 1'b0;
  exp_t held;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference model written from the opcode table with integer arithmetic
  function automatic exp_t model(int op, int so, int dir, int k, int cin, int a, int b, int tag);
    exp_t e;
    int r, c, z, fw, rw, ill, t, fill, out;
    r = 0; c = 0; fw = 1; rw = 1; ill = 0; z = -1;
    case (op)
      0: begin r = b; c = cin; fw = 0; z = 0; end
      1: r = a & b;
      2: r = a | b;
      3: r = a ^ b;
      4: begin r = (a + b) % 256; c = (a + b > 255); end
      5: begin r = (a + b + cin) % 256; c = (a + b + cin > 255); end
      6: begin r = (a - b + 256) % 256; c = (a < b); end
      7: begin r = (a - b - cin + 512) % 256; c = (a < b + cin); end
      8: begin r = a; c = (a < b); z = (a == b); rw = 0; end
      9: begin t = a & b; r = a; c = $countones(t) % 2; z = (t == 0); rw = 0; end
      10: begin
        if (dir != 0) begin
          out = a % 2;
          fill = (so == 0) ? k : (so == 1) ? a / 128 : (so == 2) ? cin : out;
          r = a / 2 + fill * 128;
        end else begin
          out = a / 128;
          fill = (so == 0) ? k : (so == 1) ? a % 2 : (so == 2) ? cin : out;
          r = (a * 2) % 256 + fill;
        end
        c = out;
      end
      default: begin fw = 0; rw = 0; ill = 1; z = 0; end
    endcase
    if (z < 0) z = (r == 0);
    e.tag = tag[3:0]; e.res = r[7:0]; e.c = c[0]; e.z = z[0];
    e.fw = fw[0]; e.rw = rw[0]; e.ill = ill[0];
    return e;
  endfunction

  // Consumer-side ready pattern, changed just after each rising edge
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0: res_ready = 1'b1;
      1: res_ready = ~res_ready;
      2: res_ready = ($urandom_range(0, 3) != 0);
      default: res_ready = 1'b0;
    endcase
  end

  // Monitor: samples on the falling edge, pops and compares on output transfers
  always @(negedge clk) begin
    exp_t cur, e;
    cur = {res_tag, result, carry_out, zero_out, flags_we, reg_we, illegal};
    if (reset) begin
      held_v = 1'b0;
      mon_ret = 0;
      mon_ill = 0;
    end else begin
      if (held_v && res_valid) check("held_stable", 64'(cur), 64'(held));
      if (res_valid && res_ready) begin
        check("retired_cnt", 64'(retired_cnt), 64'(mon_ret[15:0]));
        check("illegal_cnt", 64'(illegal_cnt), 64'(mon_ill[15:0]));
        if (q.size() == 0) begin
          check("unexpected_result", 64'(cur), 64'hDEAD_BEEF);
        end else begin
          e = q.pop_front();
          check("response", 64'(cur), 64'(e));
          mon_ret++;
          if (e.ill) mon_ill++;
        end
      end
      held_v = res_valid && !res_ready;
      held = cur;
      if (op_valid && op_ready)
        q.push_back(model(int'(opcode), int'(shift_op), int'(shift_dir), int'(shift_constant),
                          int'(carry_in), int'(operand_a), int'(operand_b), int'(op_tag)));
    end
  end

  // Issue one operation and hold it until accepted (bounded)
  task automatic send(input int op, input int so, input int dir, input int k,
                      input int cin, input int a, input int b);
    int n;
    opcode = op[3:0]; shift_op = so[1:0]; shift_dir = dir[0]; shift_constant = k[0];
    carry_in = cin[0]; operand_a = a[7:0]; operand_b = b[7:0]; op_tag = tag_seq[3:0];
    op_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!op_ready && n < 200);
    if (!op_ready) begin
      check("op_ready_timeout", 64'(0), 64'(1));
    end else begin
      sent_total++;
      if (op > 10) sent_illegal++;
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    tag_seq = (tag_seq + 1) % 16;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; opcode = '0; shift_op = '0; shift_dir = 1'b0;
    shift_constant = 1'b0; carry_in = 1'b0; operand_a = '0; operand_b = '0;
    op_tag = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_retired", 64'(retired_cnt), 64'(0));
    check("rst_illegal", 64'(illegal_cnt), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed corner cases
    send(4, 0, 0, 0, 0, 8'hFF, 8'h01);   // ADD -> 00 C=1 Z=1
    send(5, 0, 0, 0, 1, 8'h7F, 8'h00);   // ADDCY -> 80
    send(6, 0, 0, 0, 0, 8'h10, 8'h20);   // SUB -> F0 C=1
    send(8, 0, 0, 0, 0, 8'h33, 8'h33);   // COMPARE -> Z=1
    send(9, 0, 0, 0, 0, 8'h07, 8'h03);   // TEST -> Z=0 C=0
    send(10, 1, 1, 0, 0, 8'h81, 8'h00);  // SR dup -> C0
    send(10, 3, 0, 0, 0, 8'h81, 8'h00);  // RL -> 03
    send(10, 0, 0, 0, 0, 8'h81, 8'h00);  // SL0 -> 02
    send(12, 0, 0, 0, 0, 8'h55, 8'hAA);  // illegal
    send(0, 0, 0, 0, 1, 8'h00, 8'h00);   // LOAD 0, Z stays 0
    send(7, 0, 0, 0, 1, 8'h05, 8'h05);   // SUBCY borrow
    drain();
    check("directed_retired", 64'(retired_cnt), 64'(sent_total));
    check("directed_illegal", 64'(illegal_cnt), 64'(sent_illegal));

    // Back-to-back tags 0..7 with alternating ready
    rr_mode = 1;
    tag_seq = 0;
    for (int i = 0; i < 8; i++)
      send($urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255),
           $urandom_range(0, 255));
    drain();
    check("b2b_retired", 64'(retired_cnt), 64'(sent_total));

    // Randomized traffic with random back-pressure
    rr_mode = 2;
    for (int i = 0; i < 300; i++)
      send($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255),
           $urandom_range(0, 255));
    rr_mode = 0;
    drain();
    check("rand_retired", 64'(retired_cnt), 64'(sent_total));
    check("rand_illegal", 64'(illegal_cnt), 64'(sent_illegal));

    // Reset with two operations in flight
    rr_mode = 3;
    repeat (2) @(posedge clk);
    #1;
    send(4, 0, 0, 0, 0, 8'h01, 8'h02);
    send(12, 0, 0, 0, 0, 8'h03, 8'h04);
    check("stall_op_ready", 64'(op_ready), 64'(0));
    reset = 1'b1;
    #1;
    check("midrst_res_valid", 64'(res_valid), 64'(0));
    check("midrst_retired", 64'(retired_cnt), 64'(0));
    check("midrst_illegal", 64'(illegal_cnt), 64'(0));
    q.delete();
    sent_total = 0;
    sent_illegal = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rr_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(res_valid), 64'(0));
    send(1, 0, 0, 0, 0, 8'hF0, 8'h0F);
    send(3, 0, 0, 0, 0, 8'hA5, 8'hA5);
    send(13, 0, 0, 0, 0, 8'h00, 8'h00);
    drain();
    check("post_rst_retired", 64'(retired_cnt), 64'(3));
    check("post_rst_illegal", 64'(illegal_cnt), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/kcpsm3_alu_responder.md
Name: kcpsm3_alu_responder

Overview:
- Clocked responder end of the ALU operation interface driven by the bench's send-op path.
- Accepts one ALU operation per cycle over a valid/ready handshake and computes the KCPSM3-style result, carry and zero.
- Returns the result over a second valid/ready handshake with a 2-stage pipeline.
- Tags and retire counters let the scoreboard align responses with issued operations.

Parameters:
- OPERAND_WIDTH, 8, operand/result width in bits.
- TAG_WIDTH, 4, width of the sequence tag passed through with each operation.
- CNT_WIDTH, 16, width of the retired and illegal operation counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- op_valid  input  1  operation present.
- op_ready  output  1  responder accepts the operation this cycle.
- opcode  input  4  operation select; encoding given in Behaviour.
- shift_op  input  2  fill-bit source: 0 constant, 1 duplicate, 2 carry, 3 rotate.
- shift_dir  input  1  0 = left, 1 = right.
- shift_constant  input  1  fill bit used when shift_op=0.
- carry_in  input  1  incoming carry flag.
- operand_a  input  OPERAND_WIDTH  first operand, also the register value.
- operand_b  input  OPERAND_WIDTH  second operand (register or constant).
- op_tag  input  TAG_WIDTH  sequence tag.
- res_valid  output  1  result present.
- res_ready  input  1  consumer accepts the result.
- result  output  OPERAND_WIDTH  computed result.
- carry_out  output  1  carry flag after the operation.
- zero_out  output  1  zero flag after the operation.
- flags_we  output  1  operation updates the flags.
- reg_we  output  1  operation writes the destination register.
- illegal  output  1  opcode is unsupported.
- res_tag  output  TAG_WIDTH  tag of the returned operation.
- retired_cnt  output  CNT_WIDTH  count of results handed off.
- illegal_cnt  output  CNT_WIDTH  count of illegal results handed off.

Behaviour:
- Reset (async) clears both stage valids and all outputs to 0; operations in flight are discarded.
- Handshake transfers:
  - An input transfer occurs when op_valid && op_ready.
  - An output transfer occurs when res_valid && res_ready.
- Stage 1 registers the operation fields. Stage 2 holds the computed response and drives the output ports.
- Stage 2 loads from stage 1 when stage 2 is empty or is transferring this cycle.
- op_ready = !v1 || stage-2-can-load. Consequences:
  - One operation per cycle is sustained under continuous res_ready.
  - Latency from accept to res_valid is 2 cycles.
- With res_ready low, both stages fill and op_ready falls. All held outputs stay stable until transfer.
- Opcodes (c = carry_in; Z = (result==0) unless stated):
  - 0 LOAD: result=b; reg_we=1, flags_we=0; carry_out=c, zero_out=0.
  - 1 AND, 2 OR, 3 XOR: bitwise a op b; carry_out=0; reg_we=1, flags_we=1.
  - 4 ADD: {carry_out,result}=a+b.
  - 5 ADDCY: {carry_out,result}=a+b+c.
  - 6 SUB: result=a-b mod 2^W; carry_out=borrow, i.e. a<b.
  - 7 SUBCY: result=a-b-c; carry_out=borrow, i.e. a<b+c.
  - Opcodes 4-7 set reg_we=1, flags_we=1.
  - 8 COMPARE: flags as SUB; result=a; reg_we=0, flags_we=1.
  - 9 TEST: t=a&b; zero_out=(t==0); carry_out=odd parity of t; result=a; reg_we=0, flags_we=1.
  - 10 SHIFT: operand a shifted 1 bit by shift_dir; carry_out=bit shifted out; reg_we=1, flags_we=1.
    - Fill bit for shift_op 0: shift_constant.
    - Fill bit for shift_op 1: the vacated end bit itself (bit7 for right, bit0 for left).
    - Fill bit for shift_op 2: c.
    - shift_op 3 is a rotate: the fill is the bit shifted out.
  - 11-15: illegal=1; result=0, carry_out=0, zero_out=0, reg_we=0, flags_we=0.
- Arithmetic is computed at OPERAND_WIDTH+1 bits; results are truncated to OPERAND_WIDTH.
- res_tag equals the op_tag of the same operation; results return in order.
- retired_cnt increments on each output transfer. illegal_cnt increments on each output transfer with illegal=1. Both wrap at 2^CNT_WIDTH.
- An input transfer and an output transfer in the same cycle are both honoured, with no bubble.

Test Plan:
- Reset asserted mid-stream with 2 operations in flight -> res_valid=0 immediately; both counters read 0; no stale result appears after reset releases.
- ADD a=0xFF, b=0x01 -> result 0x00, carry_out=1, zero_out=1. ADDCY a=0x7F, b=0x00, c=1 -> 0x80, C=0, Z=0.
- SUB a=0x10, b=0x20 -> 0xF0, C=1. COMPARE a=0x33, b=0x33 -> result 0x33, Z=1, C=0, reg_we=0. TEST a=0x07, b=0x03 -> Z=0, C=0 (parity of 0x03 even).
- SHIFT a=0x81:
  - right, shift_op=1 -> 0xC0, C=1.
  - left, shift_op=3 -> 0x03, C=1.
  - left, shift_op=0, constant 0 -> 0x02, C=1.
- Opcode 12 -> illegal=1, result 0, flags_we=0, illegal_cnt increments by 1.
- 8 back-to-back ops with tags 0-7, res_ready toggling 1010… -> all 8 returned in tag order, none lost or duplicated, retired_cnt=8, outputs held stable while res_ready=0.
